// File: rtl/time_set_h12.sv
// time_set_h12
//   12-hour time-entry block. Edit fields are preloaded from the running
//   24 h time, stepped with button pulses, and committed back to the clock
//   core in 24 h format with a one-cycle load strobe.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   btn_mode                 enter edit / advance field / commit (pulse)
//   btn_inc                  increment selected field (pulse)
//   btn_ampm                 toggle AM/PM, hour field only (pulse)
//   btn_cancel               abort edit without commit (pulse)
//   cur_hour24, cur_min      running time, sampled on edit entry
//   edit_hour12, edit_nAM_PM, edit_min   fields being edited
//   editing                  00 idle, 01 hour field, 10 minute field
//   blink                    edit-field blink, 0 when idle
//   set_hour24, set_min      committed time, valid with set_valid
//   set_valid                one-cycle load strobe
module time_set_h12 #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_ampm,
    input  logic       btn_cancel,
    input  logic [4:0] cur_hour24,
    input  logic [5:0] cur_min,
    output logic [3:0] edit_hour12,
    output logic       edit_nAM_PM,
    output logic [5:0] edit_min,
    output logic [1:0] editing,
    output logic       blink,
    output logic [4:0] set_hour24,
    output logic [5:0] set_min,
    output logic       set_valid
);

    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN, COMMIT} state_t;

    state_t        state, next_state;
    logic [CW-1:0] blink_cnt;

    // 24h -> 12h for edit preload
    logic [3:0] load_h12;
    logic       load_pm;
    // 12h -> 24h for commit
    logic [4:0] commit_h24;

    always_comb begin
        load_pm  = (cur_hour24 >= 5'd12);
        load_h12 = cur_hour24[3:0];
        if (cur_hour24 == 5'd0)
            load_h12 = 4'd12;
        else if (cur_hour24 > 5'd12)
            load_h12 = 4'(cur_hour24 - 5'd12);
    end

    always_comb begin
        if (edit_hour12 == 4'd12)
            commit_h24 = edit_nAM_PM ? 5'd12 : 5'd0;
        else
            commit_h24 = edit_nAM_PM ? (5'(edit_hour12) + 5'd12) : 5'(edit_hour12);
    end

    // Cancel dominates, then mode; inc/ampm act only when neither fires.
    always_comb begin
        next_state = state;
        editing    = 2'b00;
        case (state)
            IDLE:     if (btn_mode) next_state = SET_HOUR;
            SET_HOUR: begin
                editing = 2'b01;
                if (btn_cancel)    next_state = IDLE;
                else if (btn_mode) next_state = SET_MIN;
            end
            SET_MIN: begin
                editing = 2'b10;
                if (btn_cancel)    next_state = IDLE;
                else if (btn_mode) next_state = COMMIT;
            end
            COMMIT:   next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            edit_hour12 <= 4'd12;
            edit_nAM_PM <= 1'b0;
            edit_min    <= 6'd0;
            set_hour24  <= 5'd0;
            set_min     <= 6'd0;
            set_valid   <= 1'b0;
            blink       <= 1'b0;
            blink_cnt   <= '0;
        end else begin
            state     <= next_state;
            set_valid <= 1'b0;

            case (state)
                IDLE: if (btn_mode) begin
                    edit_hour12 <= load_h12;
                    edit_nAM_PM <= load_pm;
                    edit_min    <= cur_min;
                end
                SET_HOUR: if (!btn_cancel && !btn_mode) begin
                    if (btn_inc)
                        edit_hour12 <= (edit_hour12 == 4'd12) ? 4'd1 : edit_hour12 + 4'd1;
                    if (btn_ampm)
                        edit_nAM_PM <= ~edit_nAM_PM;
                end
                SET_MIN: begin
                    if (!btn_cancel && !btn_mode && btn_inc)
                        edit_min <= (edit_min == 6'd59) ? 6'd0 : edit_min + 6'd1;
                    if (next_state == COMMIT) begin
                        set_hour24 <= commit_h24;
                        set_min    <= edit_min;
                        set_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase

            // Blink runs across the edit session and is cleared on the edge
            // that returns to IDLE, so it is already 0 in the first idle cycle.
            if (state != IDLE && next_state != IDLE) begin
                if (blink_cnt == CNT_MAX) begin
                    blink_cnt <= '0;
                    blink     <= ~blink;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end else begin
                blink_cnt <= '0;
                blink     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_time_set_h12.sv
module tb_time_set_h12;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_inc, btn_ampm, btn_cancel;
    logic [4:0] cur_hour24;
    logic [5:0] cur_min;
    logic [3:0] edit_hour12;
    logic       edit_nAM_PM;
    logic [5:0] edit_min;
    logic [1:0] editing;
    logic       blink;
    logic [4:0] set_hour24;
    logic [5:0] set_min;
    logic       set_valid;

    int checks = 0;
    int errors = 0;

    time_set_h12 #(.BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_ampm(btn_ampm), .btn_cancel(btn_cancel),
        .cur_hour24(cur_hour24), .cur_min(cur_min),
        .edit_hour12(edit_hour12), .edit_nAM_PM(edit_nAM_PM), .edit_min(edit_min),
        .editing(editing), .blink(blink),
        .set_hour24(set_hour24), .set_min(set_min), .set_valid(set_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of buttons; returns 1 time unit after the edge.
    task automatic btn(input logic m, input logic i, input logic a, input logic c);
        btn_mode = m; btn_inc = i; btn_ampm = a; btn_cancel = c;
        @(posedge clk); #1;
        btn_mode = 0; btn_inc = 0; btn_ampm = 0; btn_cancel = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) btn(0, 0, 0, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".editing"}, editing, 0);
        chk({tag, ".h12"}, edit_hour12, 12);
        chk({tag, ".pm"}, edit_nAM_PM, 0);
        chk({tag, ".min"}, edit_min, 0);
        chk({tag, ".set_h"}, set_hour24, 0);
        chk({tag, ".set_m"}, set_min, 0);
        chk({tag, ".valid"}, set_valid, 0);
        chk({tag, ".blink"}, blink, 0);
    endtask

    initial begin
        btn_mode = 0; btn_inc = 0; btn_ampm = 0; btn_cancel = 0;
        cur_hour24 = 0; cur_min = 0;
        rst = 1;
        idle(2);
        rst = 0;
        chk_reset("reset");

        // IDLE ignores inc/ampm/cancel
        btn(0, 1, 1, 1);
        chk("idle_ign.h12", edit_hour12, 12);
        chk("idle_ign.editing", editing, 0);

        // 1: 00:30
        cur_hour24 = 0; cur_min = 30;
        btn(1, 0, 0, 0);
        chk("t1.editing", editing, 1);
        chk("t1.h12", edit_hour12, 12);
        chk("t1.pm", edit_nAM_PM, 0);
        chk("t1.min", edit_min, 30);
        btn(1, 0, 0, 0);
        chk("t1.editing_min", editing, 2);
        chk("t1.valid_pre", set_valid, 0);
        btn(1, 0, 0, 0);
        chk("t1.valid", set_valid, 1);
        chk("t1.set_h", set_hour24, 0);
        chk("t1.set_m", set_min, 30);
        idle(1);
        chk("t1.valid_off", set_valid, 0);
        chk("t1.editing_idle", editing, 0);
        chk("t1.set_m_hold", set_min, 30);

        // 2: 11:00 -> 12 AM -> 12 PM
        cur_hour24 = 11; cur_min = 0;
        btn(1, 0, 0, 0);
        chk("t2.h12_load", edit_hour12, 11);
        btn(0, 1, 0, 0);
        chk("t2.h12_inc", edit_hour12, 12);
        chk("t2.pm_inc", edit_nAM_PM, 0);
        btn(0, 0, 1, 0);
        chk("t2.pm_toggle", edit_nAM_PM, 1);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 0);
        chk("t2.valid", set_valid, 1);
        chk("t2.set_h_pm", set_hour24, 12);
        idle(1);
        btn(1, 0, 0, 0);
        btn(0, 1, 0, 0);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 0);
        chk("t2.set_h_am", set_hour24, 0);

        // 3: 23:59, minute wraps without hour carry
        idle(1);
        cur_hour24 = 23; cur_min = 59;
        btn(1, 0, 0, 0);
        chk("t3.h12", edit_hour12, 11);
        chk("t3.pm", edit_nAM_PM, 1);
        btn(1, 0, 0, 0);
        btn(0, 1, 1, 0);   // ampm ignored in minute field
        chk("t3.min_wrap", edit_min, 0);
        chk("t3.h12_keep", edit_hour12, 11);
        chk("t3.pm_keep", edit_nAM_PM, 1);
        btn(1, 0, 0, 0);
        chk("t3.set_h", set_hour24, 23);
        chk("t3.set_m", set_min, 0);

        // 4: 17:05, twelve incs returns to 5 PM
        idle(1);
        cur_hour24 = 17; cur_min = 5;
        btn(1, 0, 0, 0);
        chk("t4.h12_load", edit_hour12, 5);
        for (int k = 0; k < 12; k++) btn(0, 1, 0, 0);
        chk("t4.h12_cycle", edit_hour12, 5);
        chk("t4.pm", edit_nAM_PM, 1);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 0);
        chk("t4.set_h", set_hour24, 17);
        chk("t4.set_m", set_min, 5);

        // 5: mode+inc, cancel, mode+cancel, cancel in COMMIT, reset mid-edit
        idle(1);
        cur_hour24 = 8; cur_min = 10;
        btn(1, 0, 0, 0);
        btn(1, 1, 0, 0);
        chk("t5.editing_min", editing, 2);
        chk("t5.h12_no_inc", edit_hour12, 8);
        btn(0, 0, 0, 1);
        chk("t5.cancel_editing", editing, 0);
        chk("t5.cancel_valid", set_valid, 0);
        idle(1);
        chk("t5.cancel_valid2", set_valid, 0);
        chk("t5.set_h_hold", set_hour24, 17);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 1);   // cancel beats commit
        chk("t5.modecancel_valid", set_valid, 0);
        chk("t5.modecancel_editing", editing, 0);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 0);
        chk("t5.commit_valid", set_valid, 1);
        chk("t5.commit_h", set_hour24, 8);
        btn(0, 0, 0, 1);   // cancel during COMMIT: strobe already out
        chk("t5.commit_cancel_valid", set_valid, 0);
        btn(1, 0, 0, 0);
        btn(0, 1, 0, 0);
        rst = 1;
        idle(1);
        rst = 0;
        chk_reset("t5.rst");

        // 6: blink with BLINK_DIV = 4
        cur_hour24 = 1; cur_min = 2;
        btn(1, 0, 0, 0);
        chk("t6.blink_e0", blink, 0);
        idle(3);
        chk("t6.blink_e3", blink, 0);
        idle(1);
        chk("t6.blink_e4", blink, 1);
        idle(3);
        chk("t6.blink_e7", blink, 1);
        idle(1);
        chk("t6.blink_e8", blink, 0);
        idle(4);
        chk("t6.blink_e12", blink, 1);
        btn(1, 0, 0, 0);
        btn(1, 0, 0, 0);
        chk("t6.commit_valid", set_valid, 1);
        chk("t6.commit_blink", blink, 1);
        idle(1);
        chk("t6.blink_cleared", blink, 0);
        idle(4);
        chk("t6.blink_idle", blink, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
